// File: rtl/riscv_execute_md.sv
// Execute stage: single-cycle ALU with operand forwarding and branch target,
// plus an iterative multiply/divide unit that holds the pipeline while it runs.
module riscv_execute_md #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [3:0]      i_alu_control_e,
  input  logic            i_alu_src_e,
  input  logic            i_zero_condition,
  input  logic [XLEN-1:0] i_rd1_e,
  input  logic [XLEN-1:0] i_rd2_e,
  input  logic [XLEN-1:0] i_result_w,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [1:0]      i_forward_a_e,
  input  logic [1:0]      i_forward_b_e,
  input  logic [XLEN-1:0] i_pc_e,
  input  logic [XLEN-1:0] i_extimm_e,
  input  logic            i_md_en_e,
  input  logic [2:0]      i_md_op_e,
  input  logic            i_flush_e,
  output logic            o_stall_e,
  output logic            o_zero_e,
  output logic [XLEN-1:0] o_alu_result_e,
  output logic [XLEN-1:0] o_write_data_e,
  output logic [XLEN-1:0] o_pc_target_e
);

  localparam int unsigned BPC   = BITS_PER_CYCLE;
  localparam int unsigned N     = XLEN / BPC;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned MW    = XLEN + BPC;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASB = 4'd10;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN:0]     r_acc_hi;
  logic [XLEN-1:0]   r_acc_lo;
  logic [XLEN-1:0]   r_opnd;
  logic [2:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;

  logic [XLEN-1:0]   w_src_a, w_src_b, w_alu_b, w_alu;
  logic [SH_W-1:0]   w_shamt;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div0, w_ovf, w_special;
  logic              w_accept, w_step, w_done;
  logic [BPC-1:0]    w_digit;
  logic [MW-1:0]     w_msum;
  logic [XLEN:0]     w_mul_hi_n;
  logic [XLEN-1:0]   w_mul_lo_n;
  logic [XLEN:0]     w_drem;
  logic [XLEN-1:0]   w_dquo;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_md_res;

  // Three-way operand forwarding for both sources
  always_comb begin
    case (i_forward_a_e)
      2'd1:    w_src_a = i_result_w;
      2'd2:    w_src_a = i_alu_result_m;
      default: w_src_a = i_rd1_e;
    endcase
    case (i_forward_b_e)
      2'd1:    w_src_b = i_result_w;
      2'd2:    w_src_b = i_alu_result_m;
      default: w_src_b = i_rd2_e;
    endcase
  end

  // Single-cycle ALU
  always_comb begin
    w_alu_b = i_alu_src_e ? i_extimm_e : w_src_b;
    w_shamt = w_alu_b[SH_W-1:0];
    case (i_alu_control_e)
      ALU_ADD:  w_alu = w_src_a + w_alu_b;
      ALU_SUB:  w_alu = w_src_a - w_alu_b;
      ALU_AND:  w_alu = w_src_a & w_alu_b;
      ALU_OR:   w_alu = w_src_a | w_alu_b;
      ALU_XOR:  w_alu = w_src_a ^ w_alu_b;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_alu_b)};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_src_a < w_alu_b};
      ALU_SLL:  w_alu = w_src_a << w_shamt;
      ALU_SRL:  w_alu = w_src_a >> w_shamt;
      ALU_SRA:  w_alu = XLEN'($signed(w_src_a) >>> w_shamt);
      ALU_PASB: w_alu = w_alu_b;
      default:  w_alu = '0;
    endcase
  end

  // Operand signs, magnitudes and the divide corner cases seen at acceptance
  always_comb begin
    w_a_sgn   = (i_md_op_e == 3'd0) || (i_md_op_e == 3'd1) || (i_md_op_e == 3'd2) ||
                (i_md_op_e == 3'd4) || (i_md_op_e == 3'd6);
    w_b_sgn   = (i_md_op_e == 3'd0) || (i_md_op_e == 3'd1) ||
                (i_md_op_e == 3'd4) || (i_md_op_e == 3'd6);
    w_a_neg   = w_a_sgn && w_src_a[XLEN-1];
    w_b_neg   = w_b_sgn && w_src_b[XLEN-1];
    w_a_mag   = w_a_neg ? (~w_src_a) + XLEN'(1) : w_src_a;
    w_b_mag   = w_b_neg ? (~w_src_b) + XLEN'(1) : w_src_b;
    w_div0    = i_md_op_e[2] && (w_src_b == '0);
    w_ovf     = i_md_op_e[2] && !i_md_op_e[0] && (w_src_a == XMIN) && (w_src_b == '1);
    w_special = w_div0 || w_ovf;
  end

  // Shift-add multiply step: BPC multiplier bits consumed from the low half
  always_comb begin
    w_digit    = r_acc_lo[BPC-1:0];
    w_msum     = MW'(r_acc_hi[XLEN-1:0]) + MW'(r_opnd) * MW'(w_digit);
    w_mul_hi_n = {1'b0, w_msum[MW-1:BPC]};
    w_mul_lo_n = {w_msum[BPC-1:0], r_acc_lo[XLEN-1:BPC]};
  end

  // Restoring divide step: BPC quotient bits per cycle
  always_comb begin
    w_drem = r_acc_hi;
    w_dquo = r_acc_lo;
    for (int i = 0; i < int'(BPC); i++) begin
      w_drem = {w_drem[XLEN-1:0], w_dquo[XLEN-1]};
      w_dquo = {w_dquo[XLEN-2:0], 1'b0};
      if (w_drem >= {1'b0, r_opnd}) begin
        w_drem    = w_drem - {1'b0, r_opnd};
        w_dquo[0] = 1'b1;
      end
    end
  end

  // Sign correction and result selection for the DONE cycle
  always_comb begin
    w_prod   = {r_acc_hi[XLEN-1:0], r_acc_lo};
    w_prod_s = r_neg_q ? (~w_prod) + (2*XLEN)'(1) : w_prod;
    w_quo_s  = r_neg_q ? (~r_acc_lo) + XLEN'(1) : r_acc_lo;
    w_rem_s  = r_neg_r ? (~r_acc_hi[XLEN-1:0]) + XLEN'(1) : r_acc_hi[XLEN-1:0];
    case (r_op)
      3'd0:       w_md_res = w_prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       w_md_res = w_prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5: w_md_res = w_quo_s;
      default:    w_md_res = w_rem_s;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // FSM next state; flush returns to IDLE from anywhere
  always_comb begin
    w_state_n = r_state;
    if (i_flush_e) begin
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_md_en_e) w_state_n = w_special ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == CNT_W'(1)) w_state_n = S_DONE;
        S_DONE:  w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // FSM outputs: stall, acceptance, iteration enable, result select
  always_comb begin
    o_stall_e = i_md_en_e && (r_state != S_DONE) && !i_flush_e;
    w_accept  = (r_state == S_IDLE) && i_md_en_e && !i_flush_e;
    w_step    = (r_state == S_CALC) && !i_flush_e;
    w_done    = (r_state == S_DONE) && !i_flush_e;
  end

  // M-unit datapath: operand latch, presets for corner cases, iteration
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_flush_e) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op <= i_md_op_e;
      r_cnt <= CNT_W'(N);
      if (w_div0) begin
        r_acc_hi <= {1'b0, w_src_a};
        r_acc_lo <= '1;
        r_opnd   <= '0;
        r_neg_q  <= 1'b0;
        r_neg_r  <= 1'b0;
      end else if (w_ovf) begin
        r_acc_hi <= '0;
        r_acc_lo <= w_src_a;
        r_opnd   <= '0;
        r_neg_q  <= 1'b0;
        r_neg_r  <= 1'b0;
      end else if (i_md_op_e[2]) begin
        r_acc_hi <= '0;
        r_acc_lo <= w_a_mag;
        r_opnd   <= w_b_mag;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
      end else begin
        r_acc_hi <= '0;
        r_acc_lo <= w_b_mag;
        r_opnd   <= w_a_mag;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= 1'b0;
      end
    end else if (w_step) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_op[2]) begin
        r_acc_hi <= w_drem;
        r_acc_lo <= w_dquo;
      end else begin
        r_acc_hi <= w_mul_hi_n;
        r_acc_lo <= w_mul_lo_n;
      end
    end
  end

  // Stage outputs
  always_comb begin
    o_alu_result_e = w_done ? w_md_res : w_alu;
    o_zero_e       = (w_alu == '0) ^ i_zero_condition;
    o_write_data_e = w_src_b;
    o_pc_target_e  = i_pc_e + i_extimm_e;
  end

endmodule

// File: tb/tb_riscv_execute_md.sv
// Bench for riscv_execute_md: a 32-bit/1-bit-per-cycle and a 64-bit/4-bit-per-cycle
// instance, directed corner cases plus random M ops against an arithmetic model.
module tb_riscv_execute_md;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  alu_ctl;
  logic        alu_src, zcond, flush;
  logic [63:0] rd1, rd2, result_w, alu_m, pc, imm;
  logic [1:0]  fwd_a, fwd_b;
  logic        md_en32, md_en64;
  logic [2:0]  md_op;

  logic        st32, z32, st64, z64;
  logic [31:0] res32, wd32, pct32;
  logic [63:0] res64, wd64, pct64;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  riscv_execute_md #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut32 (
    .i_clk(clk), .i_rstn(rstn), .i_alu_control_e(alu_ctl), .i_alu_src_e(alu_src),
    .i_zero_condition(zcond), .i_rd1_e(rd1[31:0]), .i_rd2_e(rd2[31:0]),
    .i_result_w(result_w[31:0]), .i_alu_result_m(alu_m[31:0]),
    .i_forward_a_e(fwd_a), .i_forward_b_e(fwd_b), .i_pc_e(pc[31:0]),
    .i_extimm_e(imm[31:0]), .i_md_en_e(md_en32), .i_md_op_e(md_op),
    .i_flush_e(flush), .o_stall_e(st32), .o_zero_e(z32),
    .o_alu_result_e(res32), .o_write_data_e(wd32), .o_pc_target_e(pct32));

  riscv_execute_md #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut64 (
    .i_clk(clk), .i_rstn(rstn), .i_alu_control_e(alu_ctl), .i_alu_src_e(alu_src),
    .i_zero_condition(zcond), .i_rd1_e(rd1), .i_rd2_e(rd2),
    .i_result_w(result_w), .i_alu_result_m(alu_m),
    .i_forward_a_e(fwd_a), .i_forward_b_e(fwd_b), .i_pc_e(pc),
    .i_extimm_e(imm), .i_md_en_e(md_en64), .i_md_op_e(md_op),
    .i_flush_e(flush), .o_stall_e(st64), .o_zero_e(z64),
    .o_alu_result_e(res64), .o_write_data_e(wd64), .o_pc_target_e(pct64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // RISC-V M semantics computed with wide signed arithmetic
  function automatic logic [63:0] model_md(input int w, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] one, ua, ub, sa, sb, r, t;
    logic [63:0] mask, am, bm, res;
    one  = 130'sd1;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    am   = a & mask;
    bm   = b & mask;
    ua   = $signed({66'd0, am});
    ub   = $signed({66'd0, bm});
    sa   = am[w-1] ? ua - (one <<< w) : ua;
    sb   = bm[w-1] ? ub - (one <<< w) : ub;
    r    = '0;
    case (op)
      3'd0: r = sa * sb;
      3'd1: begin t = sa * sb; r = t >>> w; end
      3'd2: begin t = sa * ub; r = t >>> w; end
      3'd3: begin t = ua * ub; r = t >>> w; end
      3'd4: begin
        if (bm == 0) r = -one;
        else if (sa == -(one <<< (w - 1)) && sb == -one) r = sa;
        else r = sa / sb;
      end
      3'd5: r = (bm == 0) ? -one : ua / ub;
      3'd6: begin
        if (bm == 0) r = sa;
        else if (sa == -(one <<< (w - 1)) && sb == -one) r = '0;
        else r = sa % sb;
      end
      default: r = (bm == 0) ? ua : ua % ub;
    endcase
    res = r[63:0];
    return res & mask;
  endfunction

  // Issue one M op, count stall cycles (bounded), check result and stall length
  task automatic run_md(input bit is64, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input string tag);
    int cyc, w, n_exp;
    logic [63:0] got, mn, mask, bm;
    w    = is64 ? 64 : 32;
    mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn   = 64'd1 << (w - 1);
    bm   = b & mask;
    n_exp = (op[2] && (bm == 0 || (!op[0] && (a & mask) == mn && bm == mask))) ? 1 :
            (is64 ? 17 : 33);
    @(negedge clk);
    fwd_a = 2'd0; fwd_b = 2'd0; flush = 1'b0;
    alu_src = 1'($urandom_range(0, 1)); imm = {$urandom, $urandom};
    rd1 = a; rd2 = b; md_op = op;
    if (is64) md_en64 = 1'b1; else md_en32 = 1'b1;
    #1;
    cyc = 0;
    while ((is64 ? st64 : st32) && cyc < 100) begin
      cyc++;
      @(negedge clk);
      rd1 = {$urandom, $urandom}; rd2 = {$urandom, $urandom};
      result_w = {$urandom, $urandom}; alu_m = {$urandom, $urandom};
      imm = {$urandom, $urandom};
      #1;
    end
    got = is64 ? res64 : {32'h0, res32};
    chk(tag, got, model_md(w, op, a, b));
    chk({tag, "_stall"}, 64'(cyc), 64'(n_exp));
    md_en32 = 1'b0; md_en64 = 1'b0;
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v, mn;
    mn = 64'd1 << (w - 1);
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = mn;
      3: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] ea, eb, eb2, e;
    rstn = 1'b0; alu_ctl = 4'd0; alu_src = 1'b0; zcond = 1'b0; flush = 1'b0;
    rd1 = 64'd1; rd2 = 64'd2; result_w = '0; alu_m = '0; pc = 64'h1000; imm = 64'h24;
    fwd_a = 2'd0; fwd_b = 2'd0; md_en32 = 1'b0; md_en64 = 1'b0; md_op = 3'd0;

    // Reset: stall low, combinational outputs follow inputs
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall32", {63'd0, st32}, 64'd0);
    chk("rst_stall64", {63'd0, st64}, 64'd0);
    chk("rst_add", {32'h0, res32}, 64'd3);
    chk("rst_wdata", {32'h0, wd32}, 64'd2);
    @(negedge clk); rstn = 1'b1;

    // Forwarding and immediate select
    @(negedge clk);
    fwd_a = 2'd2; alu_m = 64'h10; fwd_b = 2'd1; result_w = 64'h3; alu_ctl = 4'd0;
    #1;
    chk("fwd_add", {32'h0, res32}, 64'h13);
    chk("fwd_wdata", {32'h0, wd32}, 64'h3);
    alu_src = 1'b1; imm = 64'h8; pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    chk("imm_add", {32'h0, res32}, 64'h18);
    chk("pct32", {32'h0, pct32}, 64'h4);
    chk("pct64", pct64, 64'h4);
    chk("wd64", wd64, 64'h3);
    alu_ctl = 4'd1; fwd_a = 2'd0; rd1 = 64'h8; zcond = 1'b0;
    #1;
    chk("zero_sub", {63'd0, z32}, 64'd1);
    chk("zero_sub64", {63'd0, z64}, 64'd1);
    zcond = 1'b1;
    #1;
    chk("zero_qual", {63'd0, z32}, 64'd0);
    zcond = 1'b0; alu_src = 1'b0; fwd_a = 2'd0; fwd_b = 2'd0;

    // Random ALU ops with random forwarding
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd1 = {$urandom, $urandom}; rd2 = {$urandom, $urandom};
      result_w = {$urandom, $urandom}; alu_m = {$urandom, $urandom};
      imm = {$urandom, $urandom}; alu_src = 1'($urandom_range(0, 1));
      alu_ctl = 4'($urandom_range(0, 4));
      fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
      #1;
      ea  = (fwd_a == 2'd1) ? result_w[31:0] : (fwd_a == 2'd2) ? alu_m[31:0] : rd1[31:0];
      eb2 = (fwd_b == 2'd1) ? result_w[31:0] : (fwd_b == 2'd2) ? alu_m[31:0] : rd2[31:0];
      eb  = alu_src ? imm[31:0] : eb2;
      case (alu_ctl)
        4'd0:    e = ea + eb;
        4'd1:    e = ea - eb;
        4'd2:    e = ea & eb;
        4'd3:    e = ea | eb;
        default: e = ea ^ eb;
      endcase
      chk("alu_rand", {32'h0, res32}, {32'h0, e});
      chk("alu_wdata", {32'h0, wd32}, {32'h0, eb2});
    end
    alu_ctl = 4'd0;

    // Directed M ops (second and later ones are back-to-back)
    run_md(1'b0, 3'd0, 64'd7, 64'hFFFF_FFFD, "mul_7_m3");
    run_md(1'b0, 3'd1, 64'h8000_0000, 64'h8000_0000, "mulh_min");
    run_md(1'b0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhu_max");
    run_md(1'b0, 3'd2, 64'hFFFF_FFFF, 64'd2, "mulhsu_m1_2");
    run_md(1'b0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, "div_ovf");
    run_md(1'b0, 3'd5, 64'd5, 64'd0, "divu_by0");
    run_md(1'b0, 3'd6, 64'd5, 64'd0, "rem_by0");
    run_md(1'b0, 3'd6, 64'hFFFF_FFF9, 64'd2, "rem_m7_2");
    run_md(1'b0, 3'd4, 64'hFFFF_FFF9, 64'd2, "div_m7_2");
    run_md(1'b1, 3'd5, 64'd100, 64'd7, "divu64_100_7");
    run_md(1'b1, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "mulh64_min");

    // Flush in the middle of CALC, then a full op
    @(negedge clk);
    fwd_a = 2'd0; fwd_b = 2'd0; rd1 = 64'd5; rd2 = 64'd6; md_op = 3'd0; md_en32 = 1'b1;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", {63'd0, st32}, 64'd0);
    @(negedge clk);
    flush = 1'b0; md_en32 = 1'b0;
    #1;
    chk("flush_idle", {63'd0, st32}, 64'd0);
    run_md(1'b0, 3'd0, 64'd3, 64'd4, "mul_after_flush");

    // Reset in the middle of CALC, then a full op
    @(negedge clk);
    rd1 = 64'd9; rd2 = 64'd2; md_op = 3'd5; md_en32 = 1'b1;
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; md_en32 = 1'b0;
    #1;
    chk("rst_mid_stall", {63'd0, st32}, 64'd0);
    run_md(1'b0, 3'd5, 64'd100, 64'd7, "divu_after_rst");

    // Random M ops on both configurations
    for (int i = 0; i < 30; i++)
      run_md(1'b0, 3'($urandom_range(0, 7)), pick(32), pick(32), "rand32");
    for (int i = 0; i < 12; i++)
      run_md(1'b1, 3'($urandom_range(0, 7)), pick(64), pick(64), "rand64");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
